threshold_subtractor: RTL and testbench
=======================================

# threshold_subtractor

Sequential repeated-subtraction unit: the inverse of the integrate path that accumulates into neuron potential with signed adders. It accepts a signed membrane potential and a signed threshold, subtracts the threshold once per cycle while potential ≥ threshold, and returns the residual potential and the number of subtractions (spike count). It sits after potential integration in the neuron block, on a valid/ready stream on both sides.

## Interface
Parameters:
- DATA_WIDTH, 9: width of potential and residual, signed two's complement.
- THRESH_WIDTH, 9: width of threshold, signed; must be ≤ DATA_WIDTH.
- COUNT_WIDTH, 4: width of spike_count, unsigned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  potential/threshold present.
- in_ready  out  1  block can accept; high only in IDLE.
- potential  in  DATA_WIDTH  signed starting potential.
- threshold  in  THRESH_WIDTH  signed threshold; sign-extended to DATA_WIDTH internally.
- out_valid  out  1  result present; high only in DONE.
- out_ready  in  1  consumer takes result.
- residual  out  DATA_WIDTH  signed potential after subtractions.
- spike_count  out  COUNT_WIDTH  subtractions performed.
- count_sat  out  1  stopped because spike_count reached 2^COUNT_WIDTH-1 while residual ≥ threshold.

## Operation
- States: IDLE, SUB, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, latch p=potential, t=sign-extended threshold, clear count and count_sat. If t ≤ 0, go to DONE directly (no subtraction, count 0, residual = potential). Otherwise go to SUB.
- SUB, one compare per cycle:
  - p ≥ t (signed) and count < 2^COUNT_WIDTH-1: p ← p − t, count ← count+1, stay in SUB.
  - p ≥ t and count = max: count_sat ← 1, go to DONE, p unchanged.
  - p < t: go to DONE.
- Arithmetic: compare and subtract are done at DATA_WIDTH+1 bits. With p ≥ t > 0 the result lies in [0, p), so no overflow is possible. Negative p exits on the first compare.
- DONE: out_valid=1. residual=p, spike_count=count and count_sat are driven from registers and held stable while out_valid & !out_ready. On out_valid & out_ready, go to IDLE.
- No overlap: a new input is accepted only in IDLE, so in_valid during SUB/DONE is ignored (in_ready=0).
- Reset (asynchronous, any state, including mid-SUB): state=IDLE, in_ready=1 once rst_n is high, out_valid=0, residual=0, spike_count=0, count_sat=0. The operation in flight is discarded.

## Timing
- Accepting edge E0. With k subtractions performed and t > 0, the block spends k+1 cycles in SUB. out_valid rises after edge E0+k+1.
- Saturated case: k = 2^COUNT_WIDTH-1, so out_valid rises after E0+k+1, with count_sat=1.
- t ≤ 0: out_valid rises after E0+1.
- The output handshake completes on the edge where out_valid & out_ready. in_ready is high on the following cycle.
- Minimum initiation interval: k+3 cycles (t > 0).
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready to any output.

## Test plan
- potential=100, threshold=30, out_ready=1 → out_valid after E0+4; residual=10, spike_count=3, count_sat=0; in_ready=1 on the next cycle.
- potential=−5, threshold=10 → out_valid after E0+1+0 compare (E0+1); residual=−5, spike_count=0, count_sat=0.
- potential=255, threshold=1 (COUNT_WIDTH=4) → out_valid after E0+16; spike_count=15, residual=240, count_sat=1.
- threshold=0 and threshold=−3 with potential=42 → out_valid after E0+1; residual=42, spike_count=0, count_sat=0.
- Backpressure: potential=60, threshold=20, out_ready low for 5 cycles → residual=0, spike_count=3 held stable; in_ready=0 throughout. A pulsed in_valid during this window is ignored. After out_ready, IDLE is reached and a new input is accepted.
- Reset mid-operation: potential=200, threshold=10; drop rst_n asynchronously after 3 SUB cycles → all outputs 0 and out_valid=0 immediately. After release, in_ready=1 and a fresh 50/7 input yields residual=1, spike_count=7.

Source files
------------

// File: rtl/threshold_subtractor.sv
// threshold_subtractor: repeated signed subtraction of a threshold from a
// membrane potential, producing the residual potential and the spike count.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a potential/threshold pair, in_ready high
// SUB   | one compare per cycle, subtracting while p >= t and count < max
// DONE  | result held on residual/spike_count/count_sat, out_valid high
module threshold_subtractor #(
    parameter int DATA_WIDTH   = 9,
    parameter int THRESH_WIDTH = 9,
    parameter int COUNT_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH-1:0]   potential,
    input  logic signed [THRESH_WIDTH-1:0] threshold,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_WIDTH-1:0]   residual,
    output logic [COUNT_WIDTH-1:0]         spike_count,
    output logic                           count_sat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        state_q, state_nxt;
    logic signed [DATA_WIDTH-1:0]  p_q, p_nxt;
    logic signed [DATA_WIDTH-1:0]  t_q, t_nxt;
    logic [COUNT_WIDTH-1:0]        cnt_q, cnt_nxt;
    logic                          sat_q, sat_nxt;

    logic signed [DATA_WIDTH-1:0]  t_in;
    logic                          t_in_nonpos;
    logic signed [DATA_WIDTH:0]    diff;
    logic                          p_ge_t;
    logic                          cnt_max;

    // Threshold is sign-extended up to the potential width on entry.
    assign t_in        = DATA_WIDTH'(threshold);
    assign t_in_nonpos = t_in[DATA_WIDTH-1] || (t_in == '0);

    // One extra bit keeps the compare exact for any signed p and t.
    assign diff    = (DATA_WIDTH+1)'(p_q) - (DATA_WIDTH+1)'(t_q);
    assign p_ge_t  = ~diff[DATA_WIDTH];
    assign cnt_max = &cnt_q;

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            t_q     <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            p_q     <= p_nxt;
            t_q     <= t_nxt;
            cnt_q   <= cnt_nxt;
            sat_q   <= sat_nxt;
        end
    end

    // Next-state and datapath update: hold everything unless a transition says otherwise.
    always_comb begin
        state_nxt = state_q;
        p_nxt     = p_q;
        t_nxt     = t_q;
        cnt_nxt   = cnt_q;
        sat_nxt   = sat_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    p_nxt     = potential;
                    t_nxt     = t_in;
                    cnt_nxt   = '0;
                    sat_nxt   = 1'b0;
                    // A non-positive threshold would never converge, so skip straight to the result.
                    state_nxt = t_in_nonpos ? S_DONE : S_SUB;
                end
            end
            S_SUB: begin
                if (p_ge_t && !cnt_max) begin
                    p_nxt   = diff[DATA_WIDTH-1:0];
                    cnt_nxt = cnt_q + COUNT_WIDTH'(1);
                end else if (p_ge_t) begin
                    sat_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake flags decode registered state only; results come straight from registers.
    always_comb begin
        in_ready    = (state_q == S_IDLE);
        out_valid   = (state_q == S_DONE);
        residual    = p_q;
        spike_count = cnt_q;
        count_sat   = sat_q;
    end

endmodule

// File: tb/tb_threshold_subtractor.sv
// Testbench for threshold_subtractor: table-driven vectors through a
// scoreboard queue, plus backpressure and mid-operation reset sequences.
module tb_threshold_subtractor;

    localparam int DW = 9;
    localparam int TW = 9;
    localparam int CW = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  potential;
    logic signed [TW-1:0]  threshold;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [DW-1:0]  residual;
    logic [CW-1:0]         spike_count;
    logic                  count_sat;

    int n_checks = 0;
    int n_errors = 0;

    threshold_subtractor #(
        .DATA_WIDTH  (DW),
        .THRESH_WIDTH(TW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .potential  (potential),
        .threshold  (threshold),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .residual   (residual),
        .spike_count(spike_count),
        .count_sat  (count_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat < 0 means "at most one edge after acceptance" (non-positive threshold).
    typedef struct {
        int p;
        int t;
        int res;
        int cnt;
        int sat;
        int lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one pair, wait for the result, compare against the scoreboard head.
    task automatic send(input vec_t v);
        vec_t e;
        int   w;
        int   lat;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_send", int'(in_ready), 1);
        in_valid  = 1'b1;
        potential = DW'(v.p);
        threshold = TW'(v.t);
        sb.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        if (e.lat < 0)
            chk($sformatf("latency_le1 %0d/%0d", e.p, e.t), int'(lat <= 1), 1);
        else
            chk($sformatf("latency %0d/%0d", e.p, e.t), lat, e.lat);
        chk($sformatf("residual %0d/%0d", e.p, e.t), int'(residual), e.res);
        chk($sformatf("spike_count %0d/%0d", e.p, e.t), int'(spike_count), e.cnt);
        chk($sformatf("count_sat %0d/%0d", e.p, e.t), int'(count_sat), e.sat);
        @(posedge clk);
        #1;
        chk("in_ready_after_handshake", int'(in_ready), 1);
        chk("out_valid_after_handshake", int'(out_valid), 0);
    endtask

    initial begin
        vec_t v;
        int   w;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        potential = '0;
        threshold = '0;

        vecs.push_back('{100,  30,   10,  3, 0,  4});
        vecs.push_back('{-5,   10,   -5,  0, 0,  1});
        vecs.push_back('{255,   1,  240, 15, 1, 16});
        vecs.push_back('{42,    0,   42,  0, 0, -1});
        vecs.push_back('{42,   -3,   42,  0, 0, -1});
        vecs.push_back('{30,   30,    0,  1, 0,  2});
        vecs.push_back('{29,   30,   29,  0, 0,  1});
        vecs.push_back('{15,    1,    0, 15, 0, 16});
        vecs.push_back('{16,    1,    1, 15, 1, 16});
        vecs.push_back('{-256, -256, -256, 0, 0, -1});
        vecs.push_back('{255, 255,    0,  1, 0,  2});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_residual", int'(residual), 0);
        chk("reset_spike_count", int'(spike_count), 0);
        chk("reset_count_sat", int'(count_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i]);
        end

        // Backpressure: result must hold and a stray in_valid must be ignored.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        potential = 9'sd60;
        threshold = 9'sd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("bp_latency", w, 4);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                in_valid  = 1'b1;
                potential = 9'sd5;
                threshold = 9'sd1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_residual", int'(residual), 0);
            chk("bp_spike_count", int'(spike_count), 3);
            chk("bp_count_sat", int'(count_sat), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", int'(in_ready), 1);
        v = '{10, 3, 1, 3, 0, 4};
        send(v);

        // Asynchronous reset in the middle of a subtraction run.
        @(negedge clk);
        in_valid  = 1'b1;
        potential = 9'sd200;
        threshold = 9'sd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_spike_count", int'(spike_count), 3);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_residual", int'(residual), 0);
        chk("rst_spike_count", int'(spike_count), 0);
        chk("rst_count_sat", int'(count_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        v = '{50, 7, 1, 7, 0, 8};
        send(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
